lcd_text_refresher: RTL and testbench

- Downstream consumer of the 256-bit ASCII status string built by the CPU top level: 32 chars, 2 lines x 16.
- Initialises an HD44780-compatible character LCD in 4-bit mode, then repaints both lines continuously.
- Drives the LCDRS/LCDRW/LCDE/LCDDAT pins directly.
- Each frame uses a snapshot of the string, so the display never tears within a frame.

---
 rtl/lcd_text_refresher_if.sv | 21 ++
 rtl/lcd_text_refresher.sv | 261 ++++++++++++++++++++++++++
 tb/tb_lcd_text_refresher.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_text_refresher_if.sv
// Pin and status bundle between the LCD text refresher and its surroundings.
// master = refresher side (drives the LCD pins), slave = system/monitor side.
interface lcd_text_refresher_if;
    logic [255:0] strdata;
    logic         lcd_rs;
    logic         lcd_rw;
    logic         lcd_e;
    logic [3:0]   lcd_d;
    logic         ready;
    logic         frame_done;

    modport master (
        input  strdata,
        output lcd_rs, lcd_rw, lcd_e, lcd_d, ready, frame_done
    );

    modport slave (
        output strdata,
        input  lcd_rs, lcd_rw, lcd_e, lcd_d, ready, frame_done
    );
endinterface

// File: rtl/lcd_text_refresher.sv
// Inits an HD44780 LCD in 4-bit mode, then endlessly repaints 2x16 chars from a per-frame snapshot of strdata.
// Latency: one frame = 34 byte slots + 1 latch cycle; no backpressure, LCD timing is open-loop from parameters.
module lcd_text_refresher #(
    parameter int T_PWR   = 750000,
    parameter int T_INIT1 = 205000,
    parameter int T_CMD   = 2000,
    parameter int T_CLR   = 82000,
    parameter int T_SU    = 2,
    parameter int T_EH    = 12,
    parameter int T_GAP   = 50
) (
    input  logic                 clk,
    input  logic                 rst,
    lcd_text_refresher_if.master bus
);
    localparam int M1   = (T_PWR > T_INIT1) ? T_PWR : T_INIT1;
    localparam int M2   = (M1 > T_CLR) ? M1 : T_CLR;
    localparam int M3   = (M2 > T_CMD) ? M2 : T_CMD;
    localparam int M4   = (T_SU > T_EH) ? T_SU : T_EH;
    localparam int M5   = (M4 > T_GAP) ? M4 : T_GAP;
    localparam int TMAX = (M3 > M5) ? M3 : M5;
    localparam int CW   = $clog2(TMAX + 1);

    typedef logic [CW-1:0] cnt_t;

    // Down-counter reload values: a phase of N cycles loads N-1 and ends at zero.
    localparam cnt_t C_PWR   = cnt_t'(T_PWR - 1);
    localparam cnt_t C_INIT1 = cnt_t'(T_INIT1 - 1);
    localparam cnt_t C_CMD   = cnt_t'(T_CMD - 1);
    localparam cnt_t C_CLR   = cnt_t'(T_CLR - 1);
    localparam cnt_t C_SU    = cnt_t'(T_SU - 1);
    localparam cnt_t C_EH    = cnt_t'(T_EH - 1);
    localparam cnt_t C_GAP   = cnt_t'(T_GAP - 1);

    typedef enum logic [2:0] {
        ST_PWR,
        ST_LATCH,
        ST_NSU,
        ST_NEH,
        ST_NIDLE,
        ST_WAIT
    } state_e;

    typedef enum logic [2:0] {
        PH_INIT_N,
        PH_INIT_B,
        PH_ADDR1,
        PH_LINE1,
        PH_ADDR2,
        PH_LINE2
    } phase_e;

    state_e       state_q, state_d;
    phase_e       phase_q, phase_d;
    logic [1:0]   step_q, step_d;
    logic         lo_q, lo_d;
    logic [4:0]   idx_q, idx_d;
    cnt_t         cnt_q, cnt_d;
    logic [255:0] snap_q, snap_d;
    logic         lcd_rs_q, lcd_rs_d;
    logic [3:0]   lcd_d_q, lcd_d_d;
    logic         lcd_e_q, lcd_e_d;
    logic         ready_q, ready_d;
    logic         frame_done_q, frame_done_d;

    logic         start;
    cnt_t         wait_len;
    logic [7:0]   next_char;

    // Returns {rs, nibble} for the item selected by phase/step/half.
    // Init nibbles use a byte with equal halves so the half select is irrelevant.
    function automatic logic [4:0] nibble_for(input phase_e ph, input logic [1:0] st,
                                              input logic lo, input logic [7:0] ch);
        logic [7:0] b;
        logic       rs;
        b  = 8'h00;
        rs = 1'b0;
        case (ph)
            PH_INIT_N: b = (st == 2'd3) ? 8'h22 : 8'h33;
            PH_INIT_B: begin
                case (st)
                    2'd0:    b = 8'h28;
                    2'd1:    b = 8'h06;
                    2'd2:    b = 8'h0C;
                    default: b = 8'h01;
                endcase
            end
            PH_ADDR1:  b = 8'h80;
            PH_ADDR2:  b = 8'hC0;
            default: begin
                b  = ch;
                rs = 1'b1;
            end
        endcase
        return {rs, lo ? b[3:0] : b[7:4]};
    endfunction

    always_comb begin
        if (phase_q == PH_INIT_N) begin
            wait_len = (step_q == 2'd0) ? C_INIT1 : C_CMD;
        end else if (!lo_q) begin
            wait_len = C_GAP;
        end else if (phase_q == PH_INIT_B && step_q == 2'd3) begin
            wait_len = C_CLR;
        end else begin
            wait_len = C_CMD;
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        step_d       = step_q;
        lo_d         = lo_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        snap_d       = snap_q;
        lcd_rs_d     = lcd_rs_q;
        lcd_d_d      = lcd_d_q;
        lcd_e_d      = lcd_e_q;
        ready_d      = ready_q;
        frame_done_d = 1'b0;
        start        = 1'b0;
        next_char    = 8'h00;

        case (state_q)
            ST_PWR: begin
                if (cnt_q == C_PWR) begin
                    start = 1'b1;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            ST_LATCH: begin
                snap_d  = bus.strdata;
                idx_d   = 5'd0;
                lo_d    = 1'b0;
                phase_d = PH_ADDR1;
                start   = 1'b1;
            end
            ST_NSU: begin
                if (cnt_q == '0) begin
                    state_d = ST_NEH;
                    lcd_e_d = 1'b1;
                    cnt_d   = C_EH;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_NEH: begin
                if (cnt_q == '0) begin
                    state_d = ST_NIDLE;
                    lcd_e_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_NIDLE: begin
                state_d = ST_WAIT;
                cnt_d   = wait_len;
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - cnt_t'(1);
                end else if (phase_q == PH_INIT_N) begin
                    start = 1'b1;
                    if (step_q == 2'd3) begin
                        phase_d = PH_INIT_B;
                        step_d  = 2'd0;
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end else if (!lo_q) begin
                    lo_d  = 1'b1;
                    start = 1'b1;
                end else begin
                    lo_d = 1'b0;
                    case (phase_q)
                        PH_INIT_B: begin
                            if (step_q == 2'd3) begin
                                ready_d = 1'b1;
                                state_d = ST_LATCH;
                            end else begin
                                step_d = step_q + 2'd1;
                                start  = 1'b1;
                            end
                        end
                        PH_ADDR1: begin
                            phase_d = PH_LINE1;
                            start   = 1'b1;
                        end
                        PH_LINE1: begin
                            idx_d   = idx_q + 5'd1;
                            phase_d = (idx_q[3:0] == 4'hF) ? PH_ADDR2 : PH_LINE1;
                            start   = 1'b1;
                        end
                        PH_ADDR2: begin
                            phase_d = PH_LINE2;
                            start   = 1'b1;
                        end
                        default: begin
                            idx_d = idx_q + 5'd1;
                            if (idx_q == 5'd31) begin
                                frame_done_d = 1'b1;
                                state_d      = ST_LATCH;
                            end else begin
                                start = 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: state_d = ST_PWR;
        endcase

        // Launch the next nibble from the already-advanced context.
        if (start) begin
            next_char             = snap_q[{~idx_d, 3'b111} -: 8];
            state_d               = ST_NSU;
            cnt_d                 = C_SU;
            {lcd_rs_d, lcd_d_d}   = nibble_for(phase_d, step_d, lo_d, next_char);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_PWR;
            phase_q      <= PH_INIT_N;
            step_q       <= 2'd0;
            lo_q         <= 1'b0;
            idx_q        <= 5'd0;
            cnt_q        <= '0;
            snap_q       <= '0;
            lcd_rs_q     <= 1'b0;
            lcd_d_q      <= 4'h0;
            lcd_e_q      <= 1'b0;
            ready_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            step_q       <= step_d;
            lo_q         <= lo_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            snap_q       <= snap_d;
            lcd_rs_q     <= lcd_rs_d;
            lcd_d_q      <= lcd_d_d;
            lcd_e_q      <= lcd_e_d;
            ready_q      <= ready_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.lcd_rs     = lcd_rs_q;
    assign bus.lcd_rw     = 1'b0;
    assign bus.lcd_e      = lcd_e_q;
    assign bus.lcd_d      = lcd_d_q;
    assign bus.ready      = ready_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_lcd_text_refresher.sv
// Bench for lcd_text_refresher: stream model of expected nibbles plus per-cycle timing checks.
module tb_lcd_text_refresher;
    localparam int P_PWR = 20, P_INIT1 = 10, P_CMD = 8, P_CLR = 12;
    localparam int P_SU = 2, P_EH = 3, P_GAP = 2;
    localparam int NIB      = P_SU + P_EH + 1;
    localparam int READY_AT = P_PWR + 4 * NIB + P_INIT1 + 3 * P_CMD
                            + 4 * (2 * NIB + P_GAP) + 3 * P_CMD + P_CLR;
    localparam int PERIOD   = 34 * (2 * NIB + P_GAP + P_CMD) + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    lcd_text_refresher_if lif ();

    lcd_text_refresher #(
        .T_PWR(P_PWR), .T_INIT1(P_INIT1), .T_CMD(P_CMD), .T_CLR(P_CLR),
        .T_SU(P_SU), .T_EH(P_EH), .T_GAP(P_GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(lif.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [4:0] expq[$];
    logic [4:0] obs[$];

    logic [7:0] f0_chars [32] = '{
        8'h49, 8'h52, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30,
        8'h30, 8'h30, 8'h20, 8'h53, 8'h54, 8'h41, 8'h54, 8'h30,
        8'h41, 8'h4C, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30,
        8'h30, 8'h30, 8'h20, 8'h41, 8'h44, 8'h44, 8'h30, 8'h30};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_byte(input logic rs, input logic [7:0] b);
        expq.push_back({rs, b[7:4]});
        expq.push_back({rs, b[3:0]});
    endtask

    task automatic push_init();
        expq.push_back(5'h03);
        expq.push_back(5'h03);
        expq.push_back(5'h03);
        expq.push_back(5'h02);
        push_byte(1'b0, 8'h28);
        push_byte(1'b0, 8'h06);
        push_byte(1'b0, 8'h0C);
        push_byte(1'b0, 8'h01);
    endtask

    task automatic push_frame(input logic [255:0] s);
        push_byte(1'b0, 8'h80);
        for (int k = 0; k < 16; k++) push_byte(1'b1, s[8 * (31 - k) +: 8]);
        push_byte(1'b0, 8'hC0);
        for (int k = 16; k < 32; k++) push_byte(1'b1, s[8 * (31 - k) +: 8]);
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    logic [4:0] cur, rise_val, hist1, hist2, want;
    logic       e_prev, hold_pend, rise_seen, ready_prev, armed;
    int         hi_cnt, last_fd;

    initial begin
        e_prev = 0; hold_pend = 0; rise_seen = 0; ready_prev = 0; armed = 0;
        hi_cnt = 0; last_fd = 0; hist1 = 0; hist2 = 0; rise_val = 0;
    end

    always @(negedge clk) begin
        cur = {lif.lcd_rs, lif.lcd_d};
        check("rw_low", lif.lcd_rw, 0);
        if (!rst) begin
            check("rst_e", lif.lcd_e, 0);
            check("rst_rs_d", cur, 0);
            check("rst_ready", lif.ready, 0);
            check("rst_frame_done", lif.frame_done, 0);
            expq.delete();
            obs.delete();
            armed = 0; e_prev = 0; hold_pend = 0; rise_seen = 0; ready_prev = 0;
            last_fd = 0; hist1 = 0; hist2 = 0;
        end else begin
            if (!armed) begin
                push_init();
                armed = 1;
            end
            // A frame latches strdata at READY_AT and every PERIOD cycles after.
            if (cyc >= READY_AT && (cyc - READY_AT) % PERIOD == 0) push_frame(lif.strdata);
            check("ready", lif.ready, cyc >= READY_AT);
            check("frame_done", lif.frame_done, cyc > READY_AT && (cyc - READY_AT) % PERIOD == 0);
            if (lif.ready && !ready_prev) check("ready_rise_cycle", cyc, 170);
            if (lif.frame_done) begin
                if (last_fd != 0) check("frame_period", cyc - last_fd, 749);
                last_fd = cyc;
            end
            if (hold_pend) begin
                check("hold_after_fall", cur, rise_val);
                hold_pend = 0;
            end
            if (lif.lcd_e && !e_prev) begin
                if (!rise_seen) begin
                    check("first_rise_cycle", cyc, 22);
                    rise_seen = 1;
                end
                check("setup_stable", {hist2 == cur, hist1 == cur}, 2'b11);
                rise_val = cur;
                hi_cnt = 1;
            end else if (lif.lcd_e) begin
                hi_cnt++;
                check("stable_while_high", cur, rise_val);
            end else if (e_prev) begin
                check("e_width", hi_cnt, P_EH);
                check("stable_at_fall", cur, rise_val);
                check("nibble_expected", expq.size() > 0, 1);
                if (expq.size() > 0) begin
                    want = expq.pop_front();
                    check("nibble", cur, want);
                end
                obs.push_back(cur);
                hold_pend = 1;
            end
            hist2 = hist1;
            hist1 = cur;
            e_prev = lif.lcd_e;
            ready_prev = lif.ready;
        end
    end

    task automatic wait_cyc(input int t);
        int g;
        g = 0;
        while (cyc < t && g < 20000) begin
            @(posedge clk);
            #1;
            g++;
        end
    endtask

    initial begin
        logic [9:0] got, exp_b;
        logic       seen;
        lif.strdata = "IR00000000 STAT0AL00000000 ADD00";
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_e", lif.lcd_e, 0);
        check("reset_ready", lif.ready, 0);
        rst = 1'b1;

        wait_cyc(1000);
        check("f0_obs_count", obs.size() >= 80, 1);
        if (obs.size() >= 80) begin
            for (int j = 0; j < 34; j++) begin
                got = {obs[12 + 2 * j][4], obs[13 + 2 * j][4], obs[12 + 2 * j][3:0], obs[13 + 2 * j][3:0]};
                if (j == 0)       exp_b = {2'b00, 8'h80};
                else if (j == 17) exp_b = {2'b00, 8'hC0};
                else if (j < 17)  exp_b = {2'b11, f0_chars[j - 1]};
                else              exp_b = {2'b11, f0_chars[j - 2]};
                check("frame0_byte", got, exp_b);
            end
        end

        // Mid-frame change during LINE1 char 5 of frame 1.
        wait_cyc(1057);
        lif.strdata = {32{8'h2A}};

        // Change in the LATCH cycle of frame 3 must be captured.
        wait_cyc(2417);
        lif.strdata = '0;

        wait_cyc(2880);
        seen = 0;
        for (int g = 0; g < 60 && !seen; g++) begin
            @(posedge clk);
            #1;
            seen = lif.lcd_e;
        end
        check("e_high_before_reset", lif.lcd_e, 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_e_drop", lif.lcd_e, 0);
        check("async_ready_drop", lif.ready, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        wait_cyc(READY_AT + PERIOD + 5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
